// File: rtl/ntt_bank_mem.sv
//==============================================================================
// Module  : ntt_bank_mem
// Banked NTT coefficient memory: vector read/write across all banks plus a
// serial load port with completion and collision flags.
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

module ntt_bank_mem #(
  parameter int BANK_NUM = 16,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 8,
  parameter int BANK_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         r_enable,
  input  logic [BANK_NUM*ADDR_W-1:0]   rd_addr,
  output logic [BANK_NUM*DATA_W-1:0]   rd_data,
  output logic                         r_enable_out,
  input  logic                         w_enable,
  input  logic [BANK_NUM*ADDR_W-1:0]   wr_addr,
  input  logic [BANK_NUM*DATA_W-1:0]   wr_data,
  output logic                         w_enable_out,
  input  logic                         ld_en,
  input  logic [BANK_W-1:0]            ld_bank,
  input  logic [ADDR_W-1:0]            ld_addr,
  input  logic [DATA_W-1:0]            ld_data,
  output logic                         ld_done,
  output logic                         ld_err
);

  localparam int TOTAL = BANK_NUM * DEPTH;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] C_TOTAL = CNT_W'(TOTAL);

  logic                       w_ld_ok;
  logic [BANK_NUM*DATA_W-1:0] w_rd1;
  logic                       r_v1;
  logic [CNT_W-1:0]           r_ld_cnt;

  // A vector write always takes priority over the serial load port.
  assign w_ld_ok = ld_en && !w_enable;

  genvar b;
  generate
    for (b = 0; b < BANK_NUM; b++) begin : g_bank
      logic [DATA_W-1:0] r_mem [DEPTH];
      logic [DATA_W-1:0] r_q;
      logic              w_ld_sel;

      assign w_ld_sel = w_ld_ok && (ld_bank == BANK_W'(b));

      // Read samples the array in the same edge as the write, so a
      // same-address read sees the old word.
      always_ff @(posedge clk) begin
        if (w_enable)
          r_mem[wr_addr[b*ADDR_W +: ADDR_W]] <= wr_data[b*DATA_W +: DATA_W];
        else if (w_ld_sel)
          r_mem[ld_addr] <= ld_data;
        if (r_enable)
          r_q <= r_mem[rd_addr[b*ADDR_W +: ADDR_W]];
      end

      assign w_rd1[b*DATA_W +: DATA_W] = r_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1         <= 1'b0;
      r_enable_out <= 1'b0;
      rd_data      <= '0;
      w_enable_out <= 1'b0;
      r_ld_cnt     <= '0;
      ld_done      <= 1'b0;
      ld_err       <= 1'b0;
    end else begin
      r_v1         <= r_enable;
      r_enable_out <= r_v1;
      if (r_v1)
        rd_data <= w_rd1;
      w_enable_out <= w_enable;
      if (ld_en && w_enable)
        ld_err <= 1'b1;
      if (w_ld_ok && (r_ld_cnt != C_TOTAL))
        r_ld_cnt <= r_ld_cnt + CNT_W'(1);
      if ((w_ld_ok && (r_ld_cnt == C_TOTAL - CNT_W'(1))) || (r_ld_cnt == C_TOTAL))
        ld_done <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ntt_bank_mem.sv
//==============================================================================
// Module  : tb_ntt_bank_mem
// Self-checking bench for ntt_bank_mem with a read scoreboard and memory model.
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

module tb_ntt_bank_mem;

  localparam int BN = 16;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int BW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             r_enable;
  logic [BN*AW-1:0] rd_addr;
  logic [BN*DW-1:0] rd_data;
  logic             r_enable_out;
  logic             w_enable;
  logic [BN*AW-1:0] wr_addr;
  logic [BN*DW-1:0] wr_data;
  logic             w_enable_out;
  logic             ld_en;
  logic [BW-1:0]    ld_bank;
  logic [AW-1:0]    ld_addr;
  logic [DW-1:0]    ld_data;
  logic             ld_done;
  logic             ld_err;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0]    model [BN][256];
  logic [BN*DW-1:0] exp_q [$];

  ntt_bank_mem #(.BANK_NUM(BN), .DATA_W(DW), .DEPTH(256), .ADDR_W(AW), .BANK_W(BW)) dut (
    .clk(clk), .rst(rst),
    .r_enable(r_enable), .rd_addr(rd_addr), .rd_data(rd_data), .r_enable_out(r_enable_out),
    .w_enable(w_enable), .wr_addr(wr_addr), .wr_data(wr_data), .w_enable_out(w_enable_out),
    .ld_en(ld_en), .ld_bank(ld_bank), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_done(ld_done), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  function automatic logic [BN*AW-1:0] all_addr(input logic [AW-1:0] a);
    logic [BN*AW-1:0] r;
    for (int b = 0; b < BN; b++) r[b*AW +: AW] = a;
    return r;
  endfunction

  function automatic logic [BN*DW-1:0] all_data(input logic [DW-1:0] d);
    logic [BN*DW-1:0] r;
    for (int b = 0; b < BN; b++) r[b*DW +: DW] = d;
    return r;
  endfunction

  function automatic logic [BN*DW-1:0] sweep_vec(input int a);
    logic [BN*DW-1:0] r;
    for (int b = 0; b < BN; b++) r[b*DW +: DW] = DW'(b * 256 + a);
    return r;
  endfunction

  function automatic logic [BN*DW-1:0] model_rd(input logic [BN*AW-1:0] a);
    logic [BN*DW-1:0] r;
    for (int b = 0; b < BN; b++) r[b*DW +: DW] = model[b][a[b*AW +: AW]];
    return r;
  endfunction

  // One clock: queue the expected read word (pre-edge contents), then commit writes to the model.
  task automatic cycle();
    if (r_enable) exp_q.push_back(model_rd(rd_addr));
    @(posedge clk);
    if (w_enable) begin
      for (int b = 0; b < BN; b++) model[b][wr_addr[b*AW +: AW]] = wr_data[b*DW +: DW];
    end else if (ld_en) begin
      model[ld_bank][ld_addr] = ld_data;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (r_enable_out !== 1'b0) begin failures++; $display("FAIL reset_r_enable_out actual=%0b expected=0", r_enable_out); end
    checks++; if (w_enable_out !== 1'b0) begin failures++; $display("FAIL reset_w_enable_out actual=%0b expected=0", w_enable_out); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data actual=%0h expected=0", rd_data); end
    checks++; if (ld_done !== 1'b0) begin failures++; $display("FAIL reset_ld_done actual=%0b expected=0", ld_done); end
    checks++; if (ld_err !== 1'b0) begin failures++; $display("FAIL reset_ld_err actual=%0b expected=0", ld_err); end
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_load_sweep();
    logic [BN*DW-1:0] e;
    for (int i = 0; i < 4096; i++) begin
      ld_en = 1'b1; ld_bank = BW'(i / 256); ld_addr = AW'(i % 256); ld_data = DW'(i);
      cycle();
      if (i == 4094) begin
        checks++; if (ld_done !== 1'b0) begin failures++; $display("FAIL sweep_done_early actual=%0b expected=0", ld_done); end
      end
    end
    ld_en = 1'b0;
    checks++; if (ld_done !== 1'b1) begin failures++; $display("FAIL sweep_done actual=%0b expected=1", ld_done); end
    checks++; if (ld_err !== 1'b0) begin failures++; $display("FAIL sweep_err actual=%0b expected=0", ld_err); end
    r_enable = 1'b1; rd_addr = all_addr(8'd5);
    cycle();
    r_enable = 1'b0;
    checks++; if (r_enable_out !== 1'b0) begin failures++; $display("FAIL sweep_rd_lat1 actual=%0b expected=0", r_enable_out); end
    cycle();
    checks++; if (r_enable_out !== 1'b1) begin failures++; $display("FAIL sweep_rd_valid actual=%0b expected=1", r_enable_out); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++; if (rd_data !== e) begin failures++; $display("FAIL sweep_rd_sb actual=%0h expected=%0h", rd_data, e); end
    checks++; if (rd_data !== sweep_vec(5)) begin failures++; $display("FAIL sweep_rd_addr5 actual=%0h expected=%0h", rd_data, sweep_vec(5)); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, first = -1, last = -1;
    logic [BN*DW-1:0] e, last_e;
    last_e = '0;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin r_enable = 1'b1; rd_addr = all_addr(AW'(c)); end
      else r_enable = 1'b0;
      cycle();
      if (r_enable_out === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
        last = c;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        last_e = e;
        checks++; if (rd_data !== e) begin failures++; $display("FAIL b2b_data c=%0d actual=%0h expected=%0h", c, rd_data, e); end
      end
    end
    checks++; if (pulses !== 8) begin failures++; $display("FAIL b2b_pulses actual=%0d expected=8", pulses); end
    checks++; if (first !== 1 || last !== 8) begin failures++; $display("FAIL b2b_window actual=%0d..%0d expected=1..8", first, last); end
    checks++; if (rd_data !== last_e || last_e !== sweep_vec(7)) begin failures++; $display("FAIL b2b_hold actual=%0h expected=%0h", rd_data, sweep_vec(7)); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL b2b_queue actual=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_write_read();
    logic [BN*DW-1:0] e;
    w_enable = 1'b1; wr_addr = all_addr(8'd3); wr_data = all_data(64'hA5);
    r_enable = 1'b1; rd_addr = all_addr(8'd3);
    cycle();
    w_enable = 1'b0;
    checks++; if (w_enable_out !== 1'b1) begin failures++; $display("FAIL wr_ack actual=%0b expected=1", w_enable_out); end
    cycle();
    r_enable = 1'b0;
    checks++; if (w_enable_out !== 1'b0) begin failures++; $display("FAIL wr_ack_once actual=%0b expected=0", w_enable_out); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++; if (r_enable_out !== 1'b1 || rd_data !== e || e !== sweep_vec(3)) begin failures++; $display("FAIL wr_rbw_old actual=%0h expected=%0h", rd_data, sweep_vec(3)); end
    cycle();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++; if (r_enable_out !== 1'b1 || rd_data !== e || e !== all_data(64'hA5)) begin failures++; $display("FAIL wr_then_rd actual=%0h expected=%0h", rd_data, all_data(64'hA5)); end
  endtask

  task automatic test_reset_mid_read();
    int late = 0;
    r_enable = 1'b1; rd_addr = all_addr(8'd0);
    cycle();
    r_enable = 1'b0;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    exp_q.delete();
    checks++; if (r_enable_out !== 1'b0) begin failures++; $display("FAIL mid_rst_valid actual=%0b expected=0", r_enable_out); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL mid_rst_data actual=%0h expected=0", rd_data); end
    checks++; if (ld_done !== 1'b0) begin failures++; $display("FAIL mid_rst_done actual=%0b expected=0", ld_done); end
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (r_enable_out !== 1'b0) late++;
    end
    checks++; if (late !== 0) begin failures++; $display("FAIL mid_rst_late_pulse actual=%0d expected=0", late); end
  endtask

  task automatic test_collision();
    logic [BN*DW-1:0] e;
    for (int i = 0; i < 100; i++) begin
      ld_en = 1'b1; ld_bank = BW'(i / 256); ld_addr = AW'(i % 256); ld_data = DW'(i) ^ 64'h5000;
      cycle();
    end
    ld_bank = '0; ld_addr = 8'd50; ld_data = 64'hDEAD;
    w_enable = 1'b1; wr_addr = all_addr(8'd50); wr_data = all_data(64'h1234_5678_9ABC_DEF0);
    cycle();
    ld_en = 1'b0; w_enable = 1'b0;
    checks++; if (ld_err !== 1'b1) begin failures++; $display("FAIL coll_err actual=%0b expected=1", ld_err); end
    checks++; if (w_enable_out !== 1'b1) begin failures++; $display("FAIL coll_wr_ack actual=%0b expected=1", w_enable_out); end
    r_enable = 1'b1; rd_addr = all_addr(8'd50);
    cycle();
    r_enable = 1'b0;
    cycle();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++; if (r_enable_out !== 1'b1 || rd_data !== e || e !== all_data(64'h1234_5678_9ABC_DEF0)) begin failures++; $display("FAIL coll_write_wins actual=%0h expected=%0h", rd_data, all_data(64'h1234_5678_9ABC_DEF0)); end
    for (int i = 100; i < 4096; i++) begin
      ld_en = 1'b1; ld_bank = BW'(i / 256); ld_addr = AW'(i % 256); ld_data = DW'(i);
      cycle();
      if (i == 4094) begin
        checks++; if (ld_done !== 1'b0) begin failures++; $display("FAIL coll_cnt_held actual=%0b expected=0", ld_done); end
      end
    end
    ld_en = 1'b0;
    checks++; if (ld_done !== 1'b1) begin failures++; $display("FAIL coll_done actual=%0b expected=1", ld_done); end
    checks++; if (ld_err !== 1'b1) begin failures++; $display("FAIL coll_err_sticky actual=%0b expected=1", ld_err); end
  endtask

  initial begin
    rst = 1'b0; r_enable = 1'b0; rd_addr = '0; w_enable = 1'b0; wr_addr = '0; wr_data = '0;
    ld_en = 1'b0; ld_bank = '0; ld_addr = '0; ld_data = '0;
    for (int b = 0; b < BN; b++)
      for (int a = 0; a < 256; a++) model[b][a] = '0;
    test_reset();
    test_load_sweep();
    test_back_to_back();
    test_write_read();
    test_reset_mid_read();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
